udp_rx_pkt_checker: RTL

//  Sink/checker on the UDP_10G_Stack user RX AXIS port (m_axis_user_*), in the XGMII clock domain.

---
 rtl/udp_rx_pkt_checker_if.sv | 28 ++
 rtl/udp_rx_pkt_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pkt_checker_if.sv
// -----------------------------------------------------------------------------
// udp_rx_pkt_checker_if
// AXI-Stream style bus carrying the UDP stack user RX stream into the checker.
//
// Handshake: valid-only. There is no tready, so the producer can never be
// stalled. A beat is transferred in every cycle where tvalid is 1 at the
// rising clock edge. tdata/tuser/tkeep/tlast are meaningful only while tvalid
// is 1. A packet is the run of transferred beats up to and including the
// first beat with tlast=1. Idle cycles (tvalid=0) may appear between beats.
//
// Signals
//   tdata  [63:0]  payload beat, byte0 = tdata[7:0]
//   tuser  [31:0]  [15:0] packet payload byte length, [31:16] unused
//   tkeep  [7:0]   byte enables, LSB-first
//   tlast          last beat of packet
//   tvalid         beat valid
// Modports: master (stream source), slave (checker side)
// -----------------------------------------------------------------------------
interface udp_rx_pkt_checker_if;
  logic [63:0] tdata;
  logic [31:0] tuser;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;

  modport master (output tdata, tuser, tkeep, tlast, tvalid);
  modport slave  (input  tdata, tuser, tkeep, tlast, tvalid);
endinterface

// File: rtl/udp_rx_pkt_checker.sv
// -----------------------------------------------------------------------------
// udp_rx_pkt_checker
// Sink and checker for the UDP_10G_Stack user RX stream (XGMII clock domain).
// Each packet carries a sequence number S in beat 0 upper word and the
// expected payload of beat k is {S, k}. The checker verifies the pattern on
// enabled bytes, keep legality, byte length against tuser[15:0] and sequence
// continuity, then reports a per-packet result and saturating counters.
//
// Parameters
//   P_TIMEOUT  idle cycles allowed mid-packet before abort (watchdog build only)
//   P_CNT_W    width of the packet / error counters
//
// Optional feature
//   `define PKT_CHK_TIMEOUT_EN enables a mid-packet idle watchdog. Without it
//   the checker waits indefinitely for tlast.
//
// Ports
//   i_clk          XGMII clock
//   i_rst_n        asynchronous active-low reset
//   s_axis         stream input (slave modport, no back-pressure)
//   i_clr          synchronous clear of counters, sticky flag and seq lock
//   o_pkt_cnt      packets received (good + bad), saturating
//   o_err_cnt      packets with at least one error, saturating
//   o_seq_err_cnt  sequence discontinuities, saturating
//   o_pkt_done     1-cycle pulse, packet result valid (cycle after tlast)
//   o_pkt_err      qualifies o_pkt_done: 1 = packet failed
//   o_err_sticky   set on any failed packet
//   o_dbg_state    current FSM state (S_IDLE=0, S_BODY=1, S_DONE=2)
// -----------------------------------------------------------------------------
module udp_rx_pkt_checker #(
  parameter int unsigned P_TIMEOUT = 1024,
  parameter int unsigned P_CNT_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  udp_rx_pkt_checker_if.slave  s_axis,
  input  logic                 i_clr,
  output logic [P_CNT_W-1:0]   o_pkt_cnt,
  output logic [P_CNT_W-1:0]   o_err_cnt,
  output logic [15:0]          o_seq_err_cnt,
  output logic                 o_pkt_done,
  output logic                 o_pkt_err,
  output logic                 o_err_sticky,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Beat index saturates here; a beat arriving at this index is one too many.
  localparam logic [12:0] BEAT_MAX = 13'h1FFF;

  state_t      state_q, state_d;

  // Per-packet running state
  logic [12:0] beat_idx_q;
  logic [16:0] byte_cnt_q;
  logic [15:0] len_q;
  logic [31:0] cur_s_q;
  logic        err_acc_q;
  logic        seq_err_q;
  logic        pkt_err_q;

  // Sequence tracking across packets
  logic [31:0] last_s_q;
  logic        locked_q;

  // Per-beat combinational results
  logic        beat_start;
  logic        beat_body;
  logic        pkt_end;
  logic        abort;
  logic [12:0] beat_idx_cur;
  logic [31:0] s_cur;
  logic [15:0] len_cur;
  logic [63:0] exp_data;
  logic [3:0]  keep_ones;
  logic        data_err;
  logic        keep_err;
  logic        seq_err_now;
  logic        ovf_err;
  logic        len_err;
  logic        seq_err_pkt;
  logic        err_run;
  logic        pkt_err;
  logic [16:0] byte_base;
  logic [17:0] byte_sum;
  logic [16:0] byte_cnt_new;

  logic        unused_tuser_hi;
  assign unused_tuser_hi = ^s_axis.tuser[31:16];

  // ---------------------------------------------------------------------------
  // Idle watchdog
  // ---------------------------------------------------------------------------
`ifdef PKT_CHK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(P_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_q;

  // Abort on the P_TIMEOUT-th consecutive idle cycle inside a packet.
  assign abort = (state_q == S_BODY) && !s_axis.tvalid &&
                 (idle_cnt_q == TO_W'(P_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q == S_BODY) && !s_axis.tvalid) begin
      idle_cnt_q <= idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Beat evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_start   = s_axis.tvalid && (state_q != S_BODY);
    beat_body    = s_axis.tvalid && (state_q == S_BODY);
    pkt_end      = s_axis.tvalid && s_axis.tlast;
    beat_idx_cur = beat_start ? 13'd0 : beat_idx_q;
    s_cur        = beat_start ? s_axis.tdata[63:32] : cur_s_q;
    len_cur      = beat_start ? s_axis.tuser[15:0] : len_q;
    exp_data     = {s_cur, 19'd0, beat_idx_cur};

    data_err  = 1'b0;
    keep_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      keep_ones = keep_ones + {3'd0, s_axis.tkeep[i]};
      if (s_axis.tkeep[i] && (s_axis.tdata[8*i +: 8] != exp_data[8*i +: 8])) begin
        data_err = 1'b1;
      end
    end

    // A legal last-beat keep is a non-empty contiguous run from bit 0,
    // which is exactly the set of values where keep & (keep+1) == 0.
    if (s_axis.tlast) begin
      keep_err = (s_axis.tkeep == 8'h00) ||
                 ((s_axis.tkeep & (s_axis.tkeep + 8'd1)) != 8'h00);
    end else begin
      keep_err = (s_axis.tkeep != 8'hFF);
    end

    seq_err_now = beat_start && locked_q &&
                  (s_axis.tdata[63:32] != (last_s_q + 32'd1));
    ovf_err     = beat_body && (beat_idx_q == BEAT_MAX);

    byte_base    = beat_start ? 17'd0 : byte_cnt_q;
    byte_sum     = {1'b0, byte_base} +
                   (s_axis.tlast ? {14'd0, keep_ones} : 18'd8);
    byte_cnt_new = byte_sum[17] ? 17'h1FFFF : byte_sum[16:0];
    len_err      = (byte_cnt_new != {1'b0, len_cur});

    seq_err_pkt = beat_start ? seq_err_now : seq_err_q;
    err_run     = (!beat_start && err_acc_q) | data_err | keep_err |
                  seq_err_now | ovf_err;
    pkt_err     = err_run | len_err;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // S_DONE accepts a new beat 0 exactly like S_IDLE so back-to-back packets
  // are not dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (s_axis.tvalid) begin
          state_d = s_axis.tlast ? S_DONE : S_BODY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BODY: begin
        if (pkt_end || abort) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-packet accumulation
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_idx_q <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      cur_s_q    <= '0;
      err_acc_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      if (s_axis.tvalid && !s_axis.tlast) begin
        beat_idx_q <= (beat_idx_cur == BEAT_MAX) ? BEAT_MAX : beat_idx_cur + 13'd1;
        byte_cnt_q <= byte_cnt_new;
        len_q      <= len_cur;
        cur_s_q    <= s_cur;
        err_acc_q  <= err_run;
        seq_err_q  <= seq_err_pkt;
      end
      if (pkt_end || abort) begin
        pkt_err_q <= abort | pkt_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, sticky flag and sequence lock. They change on the same edge that
  // raises o_pkt_done, so they are already updated while the pulse is high.
  // An aborted packet still carried a sequence number, so it relocks too.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_cnt     <= '0;
      o_err_cnt     <= '0;
      o_seq_err_cnt <= '0;
      o_err_sticky  <= 1'b0;
      last_s_q      <= '0;
      locked_q      <= 1'b0;
    end else if (i_clr) begin
      o_pkt_cnt     <= '0;
      o_err_cnt     <= '0;
      o_seq_err_cnt <= '0;
      o_err_sticky  <= 1'b0;
      last_s_q      <= '0;
      locked_q      <= 1'b0;
    end else if (pkt_end || abort) begin
      if (~&o_pkt_cnt) begin
        o_pkt_cnt <= o_pkt_cnt + P_CNT_W'(1);
      end
      if (abort || pkt_err) begin
        o_err_sticky <= 1'b1;
        if (~&o_err_cnt) begin
          o_err_cnt <= o_err_cnt + P_CNT_W'(1);
        end
      end
      if (seq_err_pkt && (~&o_seq_err_cnt)) begin
        o_seq_err_cnt <= o_seq_err_cnt + 16'd1;
      end
      last_s_q <= s_cur;
      locked_q <= 1'b1;
    end
  end

  assign o_pkt_done  = (state_q == S_DONE);
  assign o_pkt_err   = pkt_err_q;
  assign o_dbg_state = state_q;

endmodule
